// File: rtl/match_controller.sv
// Match sequencing controller for a two-player fighting game.
// Runs a match as a series of rounds. Each round is a series of turns: both players' actions are
// collected (or timed out), issued to the fight datapath as a one-cycle strobe, and the win flags
// are sampled after a settle delay. Round wins are scored until one player reaches the target or
// the round limit runs out.
//
// Ports
//   clk                 clock, all state changes on the rising edge
//   resetGame           asynchronous active-low reset
//   start               level; begins a match from idle or from match-over
//   req1/req2, act1/2   player action requests (act valid while req high)
//   ack1/ack2           request accepted this cycle (combinational from req)
//   firstWin/secondWin  round result flags from the datapath
//   health1/health2     player health from the datapath
//   action1/action2     issued actions, held until the next issue
//   actionEnable        one-cycle issue strobe
//   roundReset_n        active-low datapath reset, low for two cycles at round start
//   score1/score2       round wins, round = current round (0 when idle)
//   matchOver           match finished, matchWinner 01=P1 10=P2 11=draw 00=none
module match_controller #(
    parameter int unsigned TURN_TIMEOUT = 8,
    parameter int unsigned SETTLE_CYC   = 2,
    parameter int unsigned TURN_LIMIT   = 16,
    parameter int unsigned WINS_NEEDED  = 2,
    parameter int unsigned MAX_ROUNDS   = 3
) (
    input  logic       clk,
    input  logic       resetGame,
    input  logic       start,
    input  logic       req1,
    input  logic       req2,
    input  logic [2:0] act1,
    input  logic [2:0] act2,
    output logic       ack1,
    output logic       ack2,
    input  logic       firstWin,
    input  logic       secondWin,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       roundReset_n,
    output logic [1:0] score1,
    output logic [1:0] score2,
    output logic [1:0] round,
    output logic       matchOver,
    output logic [1:0] matchWinner
);

    typedef enum logic [2:0] {
        StIdle, StRoundInit, StCollect, StIssue, StSettle, StRoundEnd, StMatchOver
    } state_e;

    state_e     state_q;
    logic [7:0] timer_q;
    logic [4:0] turn_q;
    logic [2:0] slot1_q, slot2_q;
    logic       full1_q, full2_q;
    logic [2:0] action1_q, action2_q;
    logic       act_en_q;
    logic       rr_n_q;
    logic [1:0] score1_q, score2_q, round_q;
    logic       over_q;
    logic [1:0] winner_q;
    logic [1:0] result_q;   // outcome of the round being closed: 01 P1, 10 P2, 11 draw

    logic       ack1_c, ack2_c, issue_go, settle_done, round_end_go, match_done;
    logic [1:0] res_d, score1_d, score2_d, winner_d;

    always_comb begin
        ack1_c       = (state_q == StCollect) && !full1_q && req1;
        ack2_c       = (state_q == StCollect) && !full2_q && req2;
        // A slot acked this cycle counts as full, so the last ack moves straight to issue.
        issue_go     = ((full1_q || ack1_c) && (full2_q || ack2_c)) ||
                       (timer_q == 8'(TURN_TIMEOUT - 1));
        settle_done  = (timer_q == 8'(SETTLE_CYC - 1));
        round_end_go = firstWin || secondWin || (turn_q == 5'(TURN_LIMIT));

        if (firstWin && !secondWin)      res_d = 2'b01;
        else if (secondWin && !firstWin) res_d = 2'b10;
        else if (firstWin && secondWin)  res_d = 2'b11;
        else if (health1 > health2)      res_d = 2'b01;
        else if (health2 > health1)      res_d = 2'b10;
        else                             res_d = 2'b11;

        score1_d = score1_q;
        score2_d = score2_q;
        if (result_q == 2'b01 && score1_q != 2'd3) score1_d = score1_q + 2'd1;
        if (result_q == 2'b10 && score2_q != 2'd3) score2_d = score2_q + 2'd1;

        match_done = (result_q == 2'b01 && score1_d == 2'(WINS_NEEDED)) ||
                     (result_q == 2'b10 && score2_d == 2'(WINS_NEEDED)) ||
                     (round_q == 2'(MAX_ROUNDS));

        if (score1_d > score2_d)      winner_d = 2'b01;
        else if (score2_d > score1_d) winner_d = 2'b10;
        else                          winner_d = 2'b11;
    end

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            turn_q    <= '0;
            slot1_q   <= '0;
            slot2_q   <= '0;
            full1_q   <= 1'b0;
            full2_q   <= 1'b0;
            action1_q <= '0;
            action2_q <= '0;
            act_en_q  <= 1'b0;
            rr_n_q    <= 1'b0;
            score1_q  <= '0;
            score2_q  <= '0;
            round_q   <= '0;
            over_q    <= 1'b0;
            winner_q  <= '0;
            result_q  <= '0;
        end else begin
            act_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    rr_n_q <= 1'b1;
                    if (start) begin
                        state_q  <= StRoundInit;
                        rr_n_q   <= 1'b0;
                        timer_q  <= '0;
                        score1_q <= '0;
                        score2_q <= '0;
                        round_q  <= 2'd1;
                    end
                end
                StRoundInit: begin
                    turn_q  <= '0;
                    slot1_q <= '0;
                    slot2_q <= '0;
                    full1_q <= 1'b0;
                    full2_q <= 1'b0;
                    if (timer_q == 8'd1) begin
                        state_q <= StCollect;
                        rr_n_q  <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StCollect: begin
                    if (ack1_c) begin
                        slot1_q <= act1;
                        full1_q <= 1'b1;
                    end
                    if (ack2_c) begin
                        slot2_q <= act2;
                        full2_q <= 1'b1;
                    end
                    if (issue_go) begin
                        // Empty slots hold 000, so a timed-out player issues 000.
                        state_q   <= StIssue;
                        act_en_q  <= 1'b1;
                        action1_q <= ack1_c ? act1 : slot1_q;
                        action2_q <= ack2_c ? act2 : slot2_q;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StIssue: begin
                    slot1_q <= '0;
                    slot2_q <= '0;
                    full1_q <= 1'b0;
                    full2_q <= 1'b0;
                    turn_q  <= turn_q + 5'd1;
                    state_q <= StSettle;
                    timer_q <= '0;
                end
                StSettle: begin
                    if (settle_done) begin
                        timer_q <= '0;
                        if (round_end_go) begin
                            result_q <= res_d;
                            state_q  <= StRoundEnd;
                        end else begin
                            state_q <= StCollect;
                        end
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StRoundEnd: begin
                    score1_q <= score1_d;
                    score2_q <= score2_d;
                    if (match_done) begin
                        state_q  <= StMatchOver;
                        over_q   <= 1'b1;
                        winner_q <= winner_d;
                    end else begin
                        round_q <= round_q + 2'd1;
                        state_q <= StRoundInit;
                        rr_n_q  <= 1'b0;
                        timer_q <= '0;
                    end
                end
                StMatchOver: begin
                    if (start) begin
                        state_q  <= StRoundInit;
                        rr_n_q   <= 1'b0;
                        timer_q  <= '0;
                        score1_q <= '0;
                        score2_q <= '0;
                        round_q  <= 2'd1;
                        over_q   <= 1'b0;
                        winner_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack1         = ack1_c;
    assign ack2         = ack2_c;
    assign action1      = action1_q;
    assign action2      = action2_q;
    assign actionEnable = act_en_q;
    assign roundReset_n = rr_n_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign round        = round_q;
    assign matchOver    = over_q;
    assign matchWinner  = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus randomized matches, all
// checked against a turn-level timing and scoring model held in the bench.
module tb_match_controller;

    localparam int unsigned T  = 8;
    localparam int unsigned S  = 2;
    localparam int unsigned TL = 16;
    localparam int unsigned WN = 2;
    localparam int unsigned MR = 3;

    logic       clk = 1'b0;
    logic       resetGame = 1'b1;
    logic       start = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [2:0] act1 = 3'd0, act2 = 3'd0;
    logic       firstWin = 1'b0, secondWin = 1'b0;
    logic [1:0] health1 = 2'd0, health2 = 2'd0;
    logic       ack1, ack2, actionEnable, roundReset_n, matchOver;
    logic [2:0] action1, action2;
    logic [1:0] score1, score2, round, matchWinner;

    int n_chk = 0;
    int n_fail = 0;

    // Match model state
    logic [1:0] m_s1, m_s2, m_round;
    int         m_turns;
    logic       m_over;

    match_controller #(
        .TURN_TIMEOUT(T), .SETTLE_CYC(S), .TURN_LIMIT(TL), .WINS_NEEDED(WN), .MAX_ROUNDS(MR)
    ) dut (
        .clk(clk), .resetGame(resetGame), .start(start),
        .req1(req1), .req2(req2), .act1(act1), .act2(act2), .ack1(ack1), .ack2(ack2),
        .firstWin(firstWin), .secondWin(secondWin), .health1(health1), .health2(health2),
        .action1(action1), .action2(action2), .actionEnable(actionEnable),
        .roundReset_n(roundReset_n), .score1(score1), .score2(score2), .round(round),
        .matchOver(matchOver), .matchWinner(matchWinner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] round_winner(logic fw, logic sw, logic [1:0] h1,
                                                logic [1:0] h2);
        if (fw && sw) return 2'b11;
        if (fw) return 2'b01;
        if (sw) return 2'b10;
        if (h1 > h2) return 2'b01;
        if (h2 > h1) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [1:0] match_winner(logic [1:0] a, logic [1:0] b);
        if (a > b) return 2'b01;
        if (b > a) return 2'b10;
        return 2'b11;
    endfunction

    task automatic do_reset();
        req1 = 1'b0; req2 = 1'b0; start = 1'b0; firstWin = 1'b0; secondWin = 1'b0;
        #2 resetGame = 1'b0;
        #1;
        n_chk++;
        if ({ack1, ack2, actionEnable, roundReset_n, matchOver, action1, action2, score1, score2,
             round, matchWinner} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero", {ack1, ack2, actionEnable,
                     roundReset_n, matchOver, action1, action2, score1, score2, round,
                     matchWinner});
        end
        tick();
        resetGame = 1'b1;
        tick();
        n_chk++;
        if ({roundReset_n, round, matchOver} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 1000", {roundReset_n, round, matchOver});
        end
    endtask

    task automatic start_match();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_s1 = 2'd0; m_s2 = 2'd0; m_round = 2'd1; m_turns = 0; m_over = 1'b0;
        n_chk++;
        if ({roundReset_n, matchOver, matchWinner, actionEnable, round, score1, score2} !==
            {1'b0, 1'b0, 2'b00, 1'b0, m_round, m_s1, m_s2}) begin
            n_fail++;
            $display("FAIL start_state: got %b want %b", {roundReset_n, matchOver, matchWinner,
                     actionEnable, round, score1, score2}, {5'b0, m_round, m_s1, m_s2});
        end
        tick();
        n_chk++;
        if (roundReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL init_second_cycle: roundReset_n got %b want 0", roundReset_n);
        end
        tick();
        n_chk++;
        if (roundReset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL init_release: roundReset_n got %b want 1", roundReset_n);
        end
    endtask

    // One turn starting at the first COLLECT cycle. Player i raises req at offset d_i and holds
    // it until the issue (a repeat request); d_i >= T means the player never gets in.
    task automatic play_turn(input int d1, input int d2, input logic fw, input logic sw,
                             input logic [1:0] h1, input logic [1:0] h2,
                             input int fa1, input int fa2);
        int         e;
        logic [2:0] exp1, exp2;
        logic       ea1, ea2, over;
        logic [1:0] res;
        e = (d1 < int'(T) && d2 < int'(T)) ? ((d1 > d2 ? d1 : d2) + 1) : int'(T);
        exp1 = 3'd0; exp2 = 3'd0;
        for (int k = 0; k <= e; k++) begin
            req1 = (k >= d1);
            req2 = (k >= d2);
            act1 = (fa1 < 0) ? 3'($urandom) : 3'(fa1);
            act2 = (fa2 < 0) ? 3'($urandom) : 3'(fa2);
            start = ($urandom_range(0, 3) == 0);
            ea1 = (k == d1) && (d1 < int'(T));
            ea2 = (k == d2) && (d2 < int'(T));
            if (ea1) exp1 = act1;
            if (ea2) exp2 = act2;
            if (k == e) begin
                firstWin = fw; secondWin = sw; health1 = h1; health2 = h2;
            end
            #1;
            if (k == 0) begin
                n_chk++;
                if ({round, score1, score2, matchOver} !== {m_round, m_s1, m_s2, 1'b0}) begin
                    n_fail++;
                    $display("FAIL turn_status: got %b want %b",
                             {round, score1, score2, matchOver}, {m_round, m_s1, m_s2, 1'b0});
                end
            end
            n_chk++;
            if ({ack1, ack2} !== {ea1, ea2}) begin
                n_fail++;
                $display("FAIL ack offset %0d: got %b want %b", k, {ack1, ack2}, {ea1, ea2});
            end
            n_chk++;
            if ({actionEnable, roundReset_n} !== {(k == e), 1'b1}) begin
                n_fail++;
                $display("FAIL strobe offset %0d: got %b want %b", k,
                         {actionEnable, roundReset_n}, {(k == e), 1'b1});
            end
            if (k == e) begin
                n_chk++;
                if ({action1, action2} !== {exp1, exp2}) begin
                    n_fail++;
                    $display("FAIL issued_actions: got %b want %b", {action1, action2},
                             {exp1, exp2});
                end
            end
            tick();
        end
        req1 = 1'b0; req2 = 1'b0; start = 1'b0;
        for (int s = 0; s < int'(S); s++) begin
            n_chk++;
            if ({actionEnable, action1, action2} !== {1'b0, exp1, exp2}) begin
                n_fail++;
                $display("FAIL settle_hold: got %b want %b", {actionEnable, action1, action2},
                         {1'b0, exp1, exp2});
            end
            tick();
        end
        m_turns++;
        if (fw || sw || m_turns == int'(TL)) begin
            res = round_winner(fw, sw, h1, h2);
            n_chk++;
            if ({score1, score2} !== {m_s1, m_s2}) begin
                n_fail++;
                $display("FAIL round_end_scores: got %b want %b", {score1, score2}, {m_s1, m_s2});
            end
            tick();
            if (res == 2'b01 && m_s1 != 2'd3) m_s1 = m_s1 + 2'd1;
            if (res == 2'b10 && m_s2 != 2'd3) m_s2 = m_s2 + 2'd1;
            over = (res == 2'b01 && m_s1 == 2'(WN)) || (res == 2'b10 && m_s2 == 2'(WN)) ||
                   (m_round == 2'(MR));
            n_chk++;
            if ({score1, score2} !== {m_s1, m_s2}) begin
                n_fail++;
                $display("FAIL scored: got %b want %b", {score1, score2}, {m_s1, m_s2});
            end
            if (over) begin
                m_over = 1'b1;
                n_chk++;
                if ({matchOver, matchWinner, round, roundReset_n} !==
                    {1'b1, match_winner(m_s1, m_s2), m_round, 1'b1}) begin
                    n_fail++;
                    $display("FAIL match_over: got %b want %b",
                             {matchOver, matchWinner, round, roundReset_n},
                             {1'b1, match_winner(m_s1, m_s2), m_round, 1'b1});
                end
            end else begin
                m_round = m_round + 2'd1;
                m_turns = 0;
                n_chk++;
                if ({matchOver, round, roundReset_n} !== {1'b0, m_round, 1'b0}) begin
                    n_fail++;
                    $display("FAIL next_round: got %b want %b", {matchOver, round, roundReset_n},
                             {1'b0, m_round, 1'b0});
                end
                tick();
                n_chk++;
                if (roundReset_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL next_round_init: roundReset_n got %b want 0", roundReset_n);
                end
                tick();
                n_chk++;
                if (roundReset_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL next_round_collect: roundReset_n got %b want 1", roundReset_n);
                end
            end
        end
    endtask

    task automatic check_over_hold(input int n);
        for (int i = 0; i < n; i++) begin
            req1 = 1'($urandom); req2 = 1'($urandom); start = 1'b0;
            #1;
            n_chk++;
            if ({ack1, ack2, actionEnable, matchOver, roundReset_n, matchWinner, round, score1,
                 score2} !== {5'b00011, match_winner(m_s1, m_s2), m_round, m_s1, m_s2}) begin
                n_fail++;
                $display("FAIL over_hold: got %b want %b", {ack1, ack2, actionEnable, matchOver,
                         roundReset_n, matchWinner, round, score1, score2},
                         {5'b00011, match_winner(m_s1, m_s2), m_round, m_s1, m_s2});
            end
            tick();
        end
        req1 = 1'b0; req2 = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        req1 = 1'b1; act1 = 3'b101; start = 1'b1;
        #2 resetGame = 1'b0;
        #1;
        n_chk++;
        if ({ack1, ack2, actionEnable, roundReset_n, matchOver, action1, action2, score1, score2,
             round, matchWinner} !== 19'd0) begin
            n_fail++;
            $display("FAIL power_on_reset: got %b want all zero", {ack1, ack2, actionEnable,
                     roundReset_n, matchOver, action1, action2, score1, score2, round,
                     matchWinner});
        end
        tick();
        resetGame = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if ({ack1, ack2, actionEnable, matchOver, round, roundReset_n} !== 7'b0000001) begin
                n_fail++;
                $display("FAIL idle_after_reset: got %b want 0000001",
                         {ack1, ack2, actionEnable, matchOver, round, roundReset_n});
            end
        end
        req1 = 1'b0;
    endtask

    task automatic test_normal_turn();
        do_reset();
        start_match();
        play_turn(0, 3, 1'b0, 1'b0, 2'd1, 2'd1, 2, 4);
    endtask

    task automatic test_timeout();
        do_reset();
        start_match();
        play_turn(0, 100, 1'b0, 1'b0, 2'd1, 2'd1, 1, -1);
        play_turn(100, 100, 1'b0, 1'b0, 2'd1, 2'd1, -1, -1);
        play_turn(100, int'(T) - 1, 1'b0, 1'b0, 2'd1, 2'd1, -1, -1);
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_match();
        play_turn(2, 2, 1'b0, 1'b0, 2'd0, 2'd0, -1, -1);
        play_turn(1, 5, 1'b0, 1'b0, 2'd0, 2'd0, -1, -1);
        play_turn(0, 0, 1'b0, 1'b0, 2'd0, 2'd0, -1, -1);
    endtask

    task automatic test_best_of_three();
        do_reset();
        start_match();
        play_turn(0, 1, 1'b1, 1'b0, 2'd0, 2'd3, -1, -1);
        play_turn(2, 0, 1'b1, 1'b0, 2'd0, 2'd3, -1, -1);
        n_chk++;
        if ({score1, score2, matchWinner, round, matchOver} !== 9'b10_00_01_10_1) begin
            n_fail++;
            $display("FAIL best_of_three: got %b want 100001101",
                     {score1, score2, matchWinner, round, matchOver});
        end
        check_over_hold(4);
    endtask

    task automatic test_draws();
        do_reset();
        start_match();
        play_turn(0, 0, 1'b1, 1'b1, 2'd0, 2'd0, -1, -1);
        for (int t = 0; t < int'(TL); t++) begin
            play_turn(int'($urandom_range(0, T)), int'($urandom_range(0, T)), 1'b0, 1'b0,
                      2'd2, 2'd2, -1, -1);
        end
        play_turn(1, 3, 1'b1, 1'b1, 2'd3, 2'd0, -1, -1);
        n_chk++;
        if ({score1, score2, matchWinner, round, matchOver} !== 9'b00_00_11_11_1) begin
            n_fail++;
            $display("FAIL all_draws: got %b want 000011111",
                     {score1, score2, matchWinner, round, matchOver});
        end
        check_over_hold(3);
        start_match();
    endtask

    task automatic test_mid_round_reset();
        do_reset();
        start_match();
        play_turn(0, 0, 1'b1, 1'b0, 2'd0, 2'd0, -1, -1);
        req1 = 1'b1; req2 = 1'b1; act1 = 3'b111; act2 = 3'b011;
        tick();
        req1 = 1'b0; req2 = 1'b0;
        n_chk++;
        if ({actionEnable, score1} !== 3'b101) begin
            n_fail++;
            $display("FAIL pre_reset_issue: got %b want 101", {actionEnable, score1});
        end
        tick();
        #2 resetGame = 1'b0;
        #1;
        n_chk++;
        if ({ack1, ack2, actionEnable, roundReset_n, matchOver, action1, action2, score1, score2,
             round, matchWinner} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_round_reset: got %b want all zero", {ack1, ack2, actionEnable,
                     roundReset_n, matchOver, action1, action2, score1, score2, round,
                     matchWinner});
        end
        tick();
        resetGame = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req1 = 1'b1; req2 = 1'b1;
            tick();
            n_chk++;
            if ({ack1, ack2, actionEnable, round, score1, score2} !== 9'd0) begin
                n_fail++;
                $display("FAIL no_ack_after_reset: got %b want 0",
                         {ack1, ack2, actionEnable, round, score1, score2});
            end
        end
        req1 = 1'b0; req2 = 1'b0;
        start_match();
    endtask

    task automatic test_random_matches();
        int   guard, d1, d2, c;
        logic limit_mode, fw, sw;
        limit_mode = 1'b0;
        do_reset();
        for (int m = 0; m < 3; m++) begin
            start_match();
            guard = 0;
            while (!m_over && guard < 200) begin
                if (m_turns == 0) limit_mode = ($urandom_range(0, 3) == 0);
                d1 = ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, T + 1));
                d2 = ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, T + 1));
                fw = 1'b0; sw = 1'b0;
                if (!limit_mode && $urandom_range(0, 2) == 0) begin
                    c = int'($urandom_range(1, 3));
                    fw = c[0]; sw = c[1];
                end
                play_turn(d1, d2, fw, sw, 2'($urandom), 2'($urandom), -1, -1);
                guard++;
            end
            n_chk++;
            if (m_over !== 1'b1) begin
                n_fail++;
                $display("FAIL random_match_end: got %b want 1 within turn budget", m_over);
            end
            check_over_hold(3);
        end
    endtask

    initial begin
        test_reset();
        test_normal_turn();
        test_timeout();
        test_simultaneous();
        test_best_of_three();
        test_draws();
        test_mid_round_reset();
        test_random_matches();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameters: TURN_TIMEOUT, 8, cycles to wait for player actions per turn (1..255).
REQ-002 SHALL have parameters: SETTLE_CYC, 2, cycles after actionEnable before sampling win flags (1..15).
REQ-003 SHALL have parameters: TURN_LIMIT, 16, max turns per round (1..31).
REQ-004 SHALL have parameters: WINS_NEEDED, 2, round wins that end the match (1..3).
REQ-005 SHALL have parameters: MAX_ROUNDS, 3, max rounds per match (1..3).
REQ-006 SHALL have ports:
- clk  in  1  single clock; all state updates on posedge.
- resetGame  in  1  asynchronous, active-low reset.
- start  in  1  level; starts a match from IDLE or MATCH_OVER.
- req1/req2  in  1  player request; the act value is valid while req is high.
- act1/act2  in  3  requested player action.
- ack1/ack2  out  1  one-cycle acceptance pulse per player.
- firstWin/secondWin  in  1  round result flags from the fight datapath.
- health1/health2  in  2  player health from the fight datapath.
- action1/action2  out  3  actions issued to the datapath.
- actionEnable  out  1  one-cycle action strobe to the datapath.
- roundReset_n  out  1  active-low datapath reset.
- score1/score2  out  2  round wins.
- round  out  2  current round number (1-based); 0 in IDLE.
- matchOver  out  1  match finished.
- matchWinner  out  2  01 = P1, 10 = P2, 11 = draw, 00 = none.

Function
REQ-007 SHALL implement states IDLE, ROUND_INIT, COLLECT, ISSUE, SETTLE, ROUND_END, MATCH_OVER.
REQ-008 IDLE: outputs stay at reset values; start=1 -> ROUND_INIT, scores cleared, round=1.
REQ-009 ROUND_INIT: roundReset_n=0 for exactly 2 cycles; turn count cleared; then -> COLLECT.
REQ-010 COLLECT: a player with empty slot and req=1 SHALL get ack=1 that cycle; act is latched into the slot.
REQ-011 A player whose slot is full SHALL get no ack; req is ignored until the next COLLECT.
REQ-012 Both slots full -> ISSUE on the next cycle.
REQ-013 Timeout: after TURN_TIMEOUT cycles in COLLECT, -> ISSUE; an empty slot SHALL issue 3'b000.
REQ-014 Simultaneous req1 and req2 in the same cycle SHALL both be acked; neither has priority.
REQ-015 ISSUE: actionEnable=1 for exactly 1 cycle, action1/action2 = slot values; slots cleared; turn count +1; -> SETTLE.
REQ-016 action1/action2 SHALL hold their issued values until the next ISSUE.
REQ-017 SETTLE: wait SETTLE_CYC cycles, then sample firstWin/secondWin.
- Either flag set -> ROUND_END.
- Neither set and turn count = TURN_LIMIT -> ROUND_END.
- Otherwise -> COLLECT.
REQ-018 ROUND_END winner SHALL be decided by the first matching rule:
- firstWin only -> P1.
- secondWin only -> P2.
- both flags -> draw.
- turn limit reached -> higher health wins; equal health -> draw.
REQ-019 ROUND_END SHALL last 1 cycle:
- winner's score +1, saturating at 3.
- If that score = WINS_NEEDED, or round = MAX_ROUNDS -> MATCH_OVER.
- Otherwise round +1 and -> ROUND_INIT.
REQ-020 A drawn round SHALL still advance round and SHALL not change any score.
REQ-021 MATCH_OVER: matchOver=1.
- matchWinner = player with the higher score; equal scores -> 11.
- Outputs held until start=1 -> ROUND_INIT with scores cleared, round=1, matchOver=0, matchWinner=00.
REQ-022 start SHALL be ignored in every state except IDLE and MATCH_OVER.
REQ-023 actionEnable and roundReset_n=0 SHALL never be asserted in the same cycle.

Reset
REQ-024 resetGame=0 SHALL immediately force state IDLE and all of the following, regardless of current state:
- ack1/ack2 = 0, actionEnable = 0.
- action1/action2 = 000.
- roundReset_n = 0 while reset is asserted, 1 after release.
- score1/score2 = 0, round = 0, matchOver = 0, matchWinner = 00.
- slots, timers and turn count cleared.
REQ-025 After reset release, SHALL stay in IDLE until start=1.

Verification
REQ-026 Normal turn: start; req1 act1=3'b010 at cycle N, req2 act2=3'b100 at cycle N+3 -> ack1@N, ack2@N+3, actionEnable@N+4 with action1=010, action2=100.
REQ-027 Timeout: only req1 (act1=001) in COLLECT -> actionEnable exactly TURN_TIMEOUT=8 cycles after COLLECT entry, action2=000.
REQ-028 Best-of-3: firstWin=1 in SETTLE for rounds 1 and 2 -> score1=1 then 2, matchOver=1, matchWinner=01, round=2, no third ROUND_INIT.
REQ-029 Draw paths, each round scoring 0 and advancing round:
- Both firstWin and secondWin set.
- TURN_LIMIT reached with health1=health2=2.
- After MAX_ROUNDS draws: matchWinner=11.
REQ-030 Mid-round reset: assert resetGame during SETTLE -> next sample shows IDLE outputs, score1=score2=0, actionEnable=0; no ack until start.
REQ-031 Simultaneous requests and repeat: req1 and req2 in the same cycle -> both acked; a second req1 before ISSUE -> no ack.
